uart_echo_buffer: RTL
=====================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 Parameter DATA_W, default 8, width of the received and transmitted character.
REQ-002 Parameter DEPTH, default 16, FIFO entries; the value SHALL be a power of two, at least 2.
REQ-003 Parameter MODE, default 1, echo transform: 0 = pass, 1 = invert if MSB set, 2 = always invert.
REQ-004 clk  in  1  single block clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 RXStatus  in  1  one-cycle strobe: RXData holds a valid received character.
REQ-007 RXData  in  DATA_W  received character, sampled only when RXStatus=1.
REQ-008 TXStatus  in  1  level: transmitter is idle and ready for a new character.
REQ-009 TXData  out  DATA_W  character to transmit; valid whenever TXEn=1.
REQ-010 TXEn  out  1  one-cycle start strobe to the transmitter.
REQ-011 Count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-012 Overflow  out  1  sticky flag: a character was dropped because the FIFO was full.

Function
REQ-013 An RXStatus=1 edge with the FIFO not full SHALL push RXData; Count SHALL increment on the same edge unless a pop also occurs.
REQ-014 An RXStatus=1 edge with the FIFO full and no pop on the same edge SHALL drop the character, leave the FIFO unchanged, and set Overflow.
REQ-015 A simultaneous push and pop SHALL both take effect when the FIFO is full; Count SHALL stay unchanged.
REQ-016 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-017 The FIFO is empty when the pointers are equal; it is full when the low bits are equal and the MSBs differ.
REQ-018 The output FSM SHALL have exactly two states, IDLE and HOLD.
REQ-019 In IDLE, with Count>0 and TXStatus=1, the next edge SHALL:
- pop the head entry;
- drive TXData = transform(head) and TXEn=1;
- move to HOLD.
REQ-020 TXEn SHALL be high for exactly one cycle per popped character and low in every other cycle.
REQ-021 TXData SHALL be registered and SHALL hold its last value while TXEn=0.
REQ-022 In HOLD, the FSM SHALL return to IDLE on the first edge that samples TXStatus=0; it SHALL stay in HOLD while TXStatus=1.
REQ-023 Transform for MODE 1: TXData = ~head when head[DATA_W-1]=1, otherwise TXData = head.
REQ-024 Transform for MODE 2: TXData = ~head.
REQ-025 Transform for MODE 0: TXData = head.
REQ-026 Minimum latency: with an empty FIFO, IDLE state and TXStatus=1, RXStatus at edge N SHALL give TXEn=1 after edge N+1.
REQ-027 A push into an empty FIFO and a pop SHALL NOT occur on the same edge; no bypass path exists.
REQ-028 Characters SHALL be transmitted in arrival order with no duplication and no loss except per REQ-014.
REQ-029 Overflow SHALL clear only on reset.

Reset
REQ-030 reset=1 at an edge SHALL:
- clear both pointers and set Count=0;
- set Overflow=0 and TXEn=0;
- set TXData to all ones;
- put the FSM in IDLE.
REQ-031 reset SHALL take priority over a push and a pop on the same edge; mid-operation reset SHALL discard all buffered characters.

Structure
REQ-032 A shared package uart_pkg SHALL hold the MODE constants (MODE_PASS, MODE_INV_MSB, MODE_INV_ALL) and the FSM state encoding.
REQ-033 Storage and pointers SHALL sit in one sub-module, sync_fifo (parameters DATA_W, DEPTH), instantiated once.
REQ-034 The FSM and the transform SHALL sit in the top level.

Verification
REQ-035 MODE=1, TXStatus=1: push 8'h41 then 8'hC1 -> TXData 8'h41 then 8'h3E, one TXEn pulse each, in order.
REQ-036 DEPTH=4, TXStatus=0: push 5 characters -> Count=4, Overflow=1, fifth character absent from the output after TXStatus rises.
REQ-037 Full FIFO, TXStatus=1: push and pop on the same edge -> Count stays 4, Overflow stays 0.
REQ-038 TXStatus held at 1 for 10 cycles after TXEn -> no second TXEn until TXStatus falls and rises again.
REQ-039 Assert reset with Count=3 and FSM in HOLD -> next cycle Count=0, TXEn=0, TXData=8'hFF, Overflow=0, no further TXEn.
REQ-040 MODE=0 and MODE=2 with input 8'h80 -> TXData 8'h80 and 8'h7F respectively.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART echo buffer: echo transform modes and the
// output FSM state encoding.
package uart_pkg;

    localparam int MODE_PASS    = 0;  // echo the character unchanged
    localparam int MODE_INV_MSB = 1;  // invert only characters with the MSB set
    localparam int MODE_INV_ALL = 2;  // invert every character

    typedef enum logic {
        IDLE = 1'b0,  // waiting for a buffered character and an idle transmitter
        HOLD = 1'b1   // character launched; waiting for the transmitter to go busy
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extended read/write pointers: one extra MSB tells full
// from empty when the index bits match. DEPTH must be a power of two, >= 2.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              wr_en, rd_en;

    // Status flags, accepted push/pop and next pointer values.
    // NOTE: every always_comb output gets a value on every path (here by
    // assigning each one unconditionally); a path that skips one infers a latch.
    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        // A same-edge read frees the slot a write into a full FIFO needs.
        wr_en  = push && (!full || pop);
        rd_en  = pop && !empty;
        wptr_d = wr_en ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = rd_en ? rptr_q + PTR_ONE : rptr_q;
        count  = wptr_q - rptr_q;
        rdata  = mem_q[rptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; stale entries are unreachable
    // once the pointers are cleared, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// UART echo buffer: received characters are queued in a FIFO and handed to the
// transmitter one at a time, optionally transformed, with a one-cycle TXEn.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int MODE   = MODE_INV_MSB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RXStatus,
    input  logic [DATA_W-1:0]      RXData,
    input  logic                   TXStatus,
    output logic [DATA_W-1:0]      TXData,
    output logic                   TXEn,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] head;

    function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] d);
        if (MODE == MODE_INV_ALL) return ~d;
        if (MODE == MODE_INV_MSB) return d[DATA_W-1] ? ~d : d;
        return d;
    endfunction

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (RXStatus),
        .pop   (pop),
        .wdata (RXData),
        .rdata (head),
        .count (Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output FSM: launch one character from IDLE, then wait in HOLD until the
    // transmitter reports busy so a level-high TXStatus cannot retrigger.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && TXStatus) begin
                    pop       = 1'b1;
                    tx_data_d = transform(head);
                    tx_en_d   = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!TXStatus) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow: a character is lost only when full with no same-edge pop.
    always_comb begin
        overflow_d = overflow_q | (RXStatus && fifo_full && !pop);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_data_q  <= '1;
            tx_en_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            overflow_q <= overflow_d;
        end
    end

    assign TXData   = tx_data_q;
    assign TXEn     = tx_en_q;
    assign Overflow = overflow_q;

endmodule
